// File: rtl/dmem_mmio_pkg.sv
// Shared address map and UART state encoding for the data-memory / MMIO block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dmem_mmio_pkg;

  // Peripheral register addresses; the low two address bits are ignored on decode
  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
  localparam logic [31:0] LED_OFFS   = 32'h0000_0000;
  localparam logic [31:0] UART_OFFS  = 32'h0000_0004;
  localparam logic [31:0] TIMER_OFFS = 32'h0000_0008;

  localparam logic [31:0] LED_ADDR   = MMIO_BASE + LED_OFFS;
  localparam logic [31:0] UART_ADDR  = MMIO_BASE + UART_OFFS;
  localparam logic [31:0] TIMER_ADDR = MMIO_BASE + TIMER_OFFS;

  // RAM always starts at address zero
  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // True when two byte addresses name the same 32-bit word
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/dmem_mmio_uart_tx_ser.sv
// UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
// Latency: tx leaves idle on the edge that accepts the byte; a frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: start is ignored while busy; the caller sees busy and must retry.
module uart_tx_ser
  import dmem_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_done;

  assign bit_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // Frame sequencer: every state holds its line level for one full bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        UART_IDLE: begin
          if (start) begin
            state    <= UART_START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= data;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        UART_START: begin
          if (bit_done) begin
            state    <= UART_DATA;
            baud_cnt <= '0;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= UART_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // tx already carries shreg[0]; expose the next bit as we shift
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        UART_STOP: begin
          if (bit_done) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            busy     <= 1'b0;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= UART_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus LED, UART and free-running timer registers behind one load/store port.
// Latency: reads are combinational from addr; writes take effect at the clock edge.
// Backpressure: none on the bus; UART writes while the serializer is busy are dropped.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] word_idx;
  logic          sel_ram;
  logic          sel_led;
  logic          sel_uart;
  logic          sel_timer;
  logic [31:0]   timer;
  logic          uart_busy;
  logic          uart_start;
  logic          unused_byte_lane;

  // Byte offset within a word never matters to this block
  assign unused_byte_lane = &{1'b0, addr[1:0]};

  assign word_idx  = addr[AW+1:2];
  assign sel_ram   = (addr[31:AW+2] == RAM_BASE[31:AW+2]);
  assign sel_led   = same_word(addr, LED_ADDR);
  assign sel_uart  = same_word(addr, UART_ADDR);
  assign sel_timer = same_word(addr, TIMER_ADDR);

  assign uart_start = we & sel_uart & ~uart_busy;

  // RAM store; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we && sel_ram) begin
      mem[word_idx] <= wdata;
    end
  end

  // LED register takes the low byte of a store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else if (we && sel_led) begin
      led <= wdata[7:0];
    end
  end

  // Free-running timer; a store overrides that cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (we && sel_timer) begin
      timer <= wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  // Load mux; unmapped addresses read as zero
  always_comb begin
    rdata = '0;
    if (sel_ram) begin
      rdata = mem[word_idx];
    end else if (sel_led) begin
      rdata = {24'b0, led};
    end else if (sel_uart) begin
      rdata = {31'b0, uart_busy};
    end else if (sel_timer) begin
      rdata = timer;
    end
  end

  uart_tx_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .start (uart_start),
    .data  (wdata[7:0]),
    .tx    (uart_tx),
    .busy  (uart_busy)
  );

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: RAM, LED, unmapped, timer wrap, UART frames, busy drop, reset mid-frame.
// Latency: inputs change on the falling edge, outputs are sampled 1ns after it.
// Backpressure: n/a.
module tb_dmem_mmio;
  import dmem_mmio_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic        uart_tx;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  dmem_mmio #(
    .RAM_WORDS   (256),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .rdata  (rdata),
    .led    (led),
    .uart_tx(uart_tx)
  );

  // Single-cycle store issued on the falling edge, committed by the next rising edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    total++; if (led !== 8'h00) begin bad++; $display("FAIL reset_led got=%h exp=00", led); end
    addr = TIMER_ADDR; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_timer got=%h exp=0", rdata); end
    addr = UART_ADDR; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", rdata); end
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(32'd1);
    @(negedge clk); addr = TIMER_ADDR; #1;
    e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL timer_first_tick got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_ram();
    @(negedge clk);
    bus_write(32'h0000_0014, 32'h1111_1111);
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h1111_1111);
    addr = 32'h0000_0010; #1; e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL ram_rd_10 got=%h exp=%h", rdata, e); end
    addr = 32'h0000_0013; #1; e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL ram_rd_13 got=%h exp=%h", rdata, e); end
    addr = 32'h0000_0014; #1; e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL ram_rd_14 got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_read_before_write();
    @(negedge clk);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hCAFE_F00D);
    addr = 32'h0000_0010; wdata = 32'hCAFE_F00D; we = 1'b1; #1;
    e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL ram_rbw_old got=%h exp=%h", rdata, e); end
    @(negedge clk); we = 1'b0; #1;
    e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL ram_rbw_new got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_led_unmapped();
    @(negedge clk);
    bus_write(32'h0000_0100, 32'h2222_2222);
    bus_write(LED_ADDR, 32'h1234_56A5);
    exp_q.push_back(32'h0000_00A5);
    #1;
    total++; if (led !== 8'hA5) begin bad++; $display("FAIL led_out got=%h exp=a5", led); end
    addr = LED_ADDR; #1; e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL led_read got=%h exp=%h", rdata, e); end
    @(negedge clk);
    bus_write(32'h8000_0100, 32'h0BAD_0BAD);
    #1;
    total++; if (led !== 8'hA5) begin bad++; $display("FAIL unmapped_led got=%h exp=a5", led); end
    addr = 32'h8000_0100; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", rdata); end
    addr = 32'h0000_0100; #1;
    total++; if (rdata !== 32'h2222_2222) begin bad++; $display("FAIL unmapped_alias got=%h exp=22222222", rdata); end
  endtask

  task automatic test_timer();
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    bus_write(TIMER_ADDR, 32'hFFFF_FFFE);
    addr = TIMER_ADDR;
    for (int i = 0; i < 3; i++) begin
      #1; e = exp_q.pop_front();
      total++; if (rdata !== e) begin bad++; $display("FAIL timer_wrap%0d got=%h exp=%h", i, rdata, e); end
      @(negedge clk);
    end
  endtask

  // Sends one byte and checks every cycle of the frame; optionally attempts a store at drop_at
  task automatic run_frame(input logic [7:0] b, input int drop_at);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) exp_q.push_back({31'b0, frame[k / CPB]});
    addr = UART_ADDR; wdata = {24'b0, b}; we = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k == drop_at) begin wdata = 32'h0000_00FF; we = 1'b1; end
      else we = 1'b0;
      #1; e = exp_q.pop_front();
      total++; if (uart_tx !== e[0]) begin bad++; $display("FAIL uart_bit byte=%h cyc=%0d got=%b exp=%b", b, k, uart_tx, e[0]); end
      total++; if (rdata !== 32'h1) begin bad++; $display("FAIL uart_busy byte=%h cyc=%0d got=%h exp=1", b, k, rdata); end
      @(negedge clk);
    end
    we = 1'b0; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL uart_done byte=%h got=%h exp=0", b, rdata); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL uart_idle byte=%h got=%b exp=1", b, uart_tx); end
  endtask

  task automatic test_uart_frame();
    @(negedge clk);
    run_frame(8'h55, -1);
  endtask

  task automatic test_back_to_back();
    run_frame(8'hA3, -1);
  endtask

  task automatic test_busy_drop();
    @(negedge clk);
    run_frame(8'h55, 10);
    for (int k = 0; k < 12 * CPB; k++) begin
      @(negedge clk); #1;
      total++; if (uart_tx !== 1'b1 || rdata !== 32'h0) begin
        bad++; $display("FAIL drop_idle cyc=%0d tx=%b busy=%h exp tx=1 busy=0", k, uart_tx, rdata);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    bus_write(32'h0000_0040, 32'h5A5A_C3C3);
    bus_write(LED_ADDR, 32'h0000_003C);
    addr = UART_ADDR; wdata = 32'h0; we = 1'b1;
    @(negedge clk); we = 1'b0;
    for (int k = 0; k < 15; k++) @(negedge clk);
    #1;
    total++; if (uart_tx !== 1'b0 || rdata !== 32'h1) begin
      bad++; $display("FAIL pre_reset tx=%b busy=%h exp tx=0 busy=1", uart_tx, rdata);
    end
    #1; rst_n = 1'b0; #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", uart_tx); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_busy got=%h exp=0", rdata); end
    total++; if (led !== 8'h00) begin bad++; $display("FAIL rst_led got=%h exp=00", led); end
    exp_q.push_back(32'h5A5A_C3C3);
    exp_q.push_back(32'h5A5A_C3C3);
    addr = 32'h0000_0040; #1; e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL rst_ram_hold got=%h exp=%h", rdata, e); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1; e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL post_rst_ram got=%h exp=%h", rdata, e); end
    addr = UART_ADDR;
    for (int k = 0; k < 2 * CPB; k++) begin
      #1;
      total++; if (uart_tx !== 1'b1 || rdata !== 32'h0) begin
        bad++; $display("FAIL post_rst_idle cyc=%0d tx=%b busy=%h exp tx=1 busy=0", k, uart_tx, rdata);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_read_before_write();
    test_led_unmapped();
    test_timer();
    test_uart_frame();
    test_back_to_back();
    test_busy_drop();
    test_reset_mid_frame();
    if (exp_q.size() != 0) begin
      total++; bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256: data RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868: UART bit period in clk cycles, minimum 2.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port addr  input  32: byte address from the core memory stage (ALU result).
REQ-006 SHALL have port we  input  1: write strobe from the core memory stage.
REQ-007 SHALL have port wdata  input  32: store data from the core memory stage.
REQ-008 SHALL have port rdata  output  32: load data returned to the core, combinational from addr.
REQ-009 SHALL have port led  output  8: LED register contents.
REQ-010 SHALL have port uart_tx  output  1: UART serial line, 8N1, idle high.

Function
REQ-011 SHALL decode the address map: RAM at 0x0000_0000 to RAM_WORDS*4-1; LED at 0x8000_0000; UART at 0x8000_0004; TIMER at 0x8000_0008.
REQ-012 SHALL index the RAM by word (addr[log2(RAM_WORDS)+1:2]) and ignore addr[1:0] for all regions.
REQ-013 SHALL write the RAM at the clock edge when we=1 and addr is in the RAM range, and read it combinationally in the same cycle (read-before-write when a write and a read target the same word).
REQ-014 SHALL return rdata=0 and ignore writes for any unmapped address.
REQ-015 SHALL load led from wdata[7:0] on a write to LED; an LED read SHALL return {24'b0, led}.
REQ-016 SHALL run TIMER as a 32-bit free-running counter: +1 per clk, wrapping 0xFFFF_FFFF to 0.
REQ-017 SHALL make a TIMER write win over the increment: the counter holds wdata after that edge and resumes incrementing on the next edge. A TIMER read SHALL return the current value.
REQ-018 SHALL accept a UART write only when busy=0; a write while busy=1 SHALL be dropped without affecting the frame in progress.
REQ-019 SHALL drive busy=1 from the edge that accepts the write until the final stop-bit cycle ends. A UART read SHALL return {31'b0, busy}.
REQ-020 SHALL implement the UART FSM as IDLE -> START -> DATA -> STOP -> IDLE, with each bit held CLKS_PER_BIT cycles.
REQ-021 SHALL drive uart_tx as follows: IDLE=1, START=0, DATA=wdata[0..7] LSB first with an internal bit index 0..7, STOP=1.
REQ-022 SHALL complete a frame in exactly 10*CLKS_PER_BIT cycles after acceptance, then enter IDLE with busy=0.
REQ-023 SHALL accept a new byte in the first IDLE cycle after STOP, giving back-to-back frames with no idle gap.

Reset
REQ-024 SHALL set led=0, TIMER=0, UART state IDLE, busy=0, bit index and baud counter =0, and uart_tx=1 immediately on rst_n=0, including mid-frame.
REQ-025 SHALL leave RAM contents unchanged by reset; their value after power-up is undefined.

Structure
REQ-026 SHALL place the address constants (region bases, register offsets) and the UART state enumeration in a shared package, dmem_mmio_pkg.
REQ-027 SHALL implement the UART serializer (FSM, baud counter, shift register, busy) as sub-module uart_tx_ser, instantiated once.

Verification
REQ-028 SHALL verify a RAM round trip: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF; a read of 0x0000_0014 is unaffected by the write.
REQ-029 SHALL verify LED and unmapped accesses: write 0x1234_56A5 to 0x8000_0000 -> led=0xA5 and a readback gives 0x0000_00A5; write to 0x8000_0100 -> no state change and a read returns 0.
REQ-030 SHALL verify the timer: write 0xFFFF_FFFE -> reads on the next three cycles return 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
REQ-031 SHALL verify a UART frame with CLKS_PER_BIT=4: write 0x55 -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles; status reads 1 during the frame and 0 after cycle 40.
REQ-032 SHALL verify busy-drop: with CLKS_PER_BIT=4, write 0x55 and then write 0xFF at cycle 10 -> the frame is unchanged and 0xFF is never transmitted.
REQ-033 SHALL verify reset mid-frame: with CLKS_PER_BIT=4, pull rst_n low at cycle 15 of a frame -> uart_tx=1 and busy=0 without waiting for clk, and a RAM word written before reset reads back unchanged.
